// File: rtl/song_reader.sv
// song_reader: walks the song ROM one note at a time and hands each
// {note, duration} pair to the note player.
//
// Each ROM word is {note[11:6], duration[5:0]}, with 32 entries per song.
// A duration of zero marks the end of the song.
//
// Optional feature: define SONG_READER_LOOP_EN to make a finished song
// restart at index 0. With the macro undefined, DONE is terminal until
// reset_player is pulsed or the song select changes.
module song_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic        reset_player,
    input  logic [3:0]  song,
    input  logic        note_done,
    output logic [8:0]  rom_addr,
    input  logic [11:0] rom_data,
    output logic [5:0]  note,
    output logic [5:0]  duration,
    output logic        new_note,
    output logic        song_done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_ROM = 3'd2,
        EMIT     = 3'd3,
        HOLD     = 3'd4,
        DONE     = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  index_q, index_d;
    logic [3:0]  song_q, song_d;
    logic [5:0]  note_q, note_d;
    logic [5:0]  dur_q, dur_d;
    logic        song_done_q, song_done_d;

    logic        restart;
    logic [5:0]  rom_note;
    logic [5:0]  rom_dur;

    assign rom_note = rom_data[11:6];
    assign rom_dur  = rom_data[5:0];

    // A song select that differs from the one latched at the last fetch
    // restarts the player, just like reset_player. IDLE is excluded because
    // IDLE already is the restart state and the new song is latched on
    // leaving it; without the exclusion play could never start a new song.
    assign restart = reset_player || ((state_q != IDLE) && (song != song_q));

    // The ROM address is purely combinational, so it follows the song
    // input with index 0 while the block is held in reset.
    assign rom_addr  = {song, index_q};
    assign note      = note_q;
    assign duration  = dur_q;
    assign song_done = song_done_q;

    // new_note is gated by play: a paused EMIT holds off the pulse until
    // play returns.
    assign new_note  = (state_q == EMIT) && play;

    // Next-state logic: restart first, then the loop-mode exit from DONE,
    // then normal progress only while play is high.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        song_d      = song_q;
        note_d      = note_q;
        dur_d       = dur_q;
        song_done_d = 1'b0;

        if (restart) begin
            state_d = IDLE;
            index_d = 5'd0;
        end else if (state_q == DONE) begin
`ifdef SONG_READER_LOOP_EN
            // DONE lasts one cycle (the song_done pulse); then the song starts again.
            index_d = 5'd0;
            if (play) begin
                state_d = FETCH;
                song_d  = song;
            end else begin
                state_d = IDLE;
            end
`else
            state_d = DONE;
`endif
        end else if (play) begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    song_d  = song;
                end
                FETCH: begin
                    state_d = WAIT_ROM;
                end
                WAIT_ROM: begin
                    if (rom_dur == 6'd0) begin
                        state_d     = DONE;
                        song_done_d = 1'b1;
                    end else begin
                        note_d  = rom_note;
                        dur_d   = rom_dur;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    state_d = HOLD;
                end
                HOLD: begin
                    if (note_done) begin
                        if (index_q == 5'd31) begin
                            state_d     = DONE;
                            song_done_d = 1'b1;
                        end else begin
                            index_d = index_q + 5'd1;
                            state_d = FETCH;
                            song_d  = song;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    index_d = 5'd0;
                end
            endcase
        end
    end

    // State and output registers, with an asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            index_q     <= 5'd0;
            song_q      <= 4'd0;
            note_q      <= 6'd0;
            dur_q       <= 6'd0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            song_q      <= song_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            song_done_q <= song_done_d;
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// Testbench for song_reader. The model describes expected behaviour at the
// event level: the list of notes a song must produce (read from the ROM
// image up to its end marker) and the cycle latency from each trigger to
// the resulting new_note / song_done pulse.
module tb_song_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        reset_player;
    logic [3:0]  song;
    logic        note_done;
    logic [8:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic        new_note;
    logic        song_done;

    logic [11:0] rom [512];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Synchronous ROM: data appears one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    song_reader dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .reset_player (reset_player),
        .song         (song),
        .note_done    (note_done),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .note         (note),
        .duration     (duration),
        .new_note     (new_note),
        .song_done    (song_done)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at the negedge of the trigger cycle. Expects new_note exactly
    // 'lat' cycles later, carrying the ROM entry exp_ent.
    task automatic wait_note(input string tag, input int lat, input logic [11:0] exp_ent);
        bit seen;
        seen = 1'b0;
        for (int k = 1; k <= lat + 4 && !seen; k++) begin
            @(posedge clk); #1;
            note_done    = 1'b0;
            reset_player = 1'b0;
            @(negedge clk);
            chk_eq({tag, "_sdone"}, 32'(song_done), 32'd0);
            if (new_note) begin
                seen = 1'b1;
                chk_eq({tag, "_lat"}, 32'(k), 32'(lat));
                chk_eq({tag, "_note"}, 32'(note), 32'(exp_ent[11:6]));
                chk_eq({tag, "_dur"}, 32'(duration), 32'(exp_ent[5:0]));
            end
        end
        if (!seen) chk_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Expects a song_done pulse exactly 'lat' cycles after the trigger
    // cycle, with no new_note on the way.
    task automatic wait_done(input string tag, input int lat);
        bit seen;
        seen = 1'b0;
        for (int k = 1; k <= lat + 4 && !seen; k++) begin
            @(posedge clk); #1;
            note_done = 1'b0;
            @(negedge clk);
            chk_eq({tag, "_nonote"}, 32'(new_note), 32'd0);
            if (song_done) begin
                seen = 1'b1;
                chk_eq({tag, "_lat"}, 32'(k), 32'(lat));
            end
        end
        if (!seen) chk_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Waits a random number of HOLD cycles, then pulses note_done. Returns
    // at the negedge of the note_done cycle.
    task automatic note_pulse();
        int gap;
        gap = int'($urandom_range(0, 3));
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            note_done = 1'b0;
            @(negedge clk);
            chk_eq("hold_quiet", 32'(new_note), 32'd0);
        end
        @(posedge clk); #1;
        note_done = 1'b1;
        @(negedge clk);
    endtask

    // While paused in HOLD, note_done must be ignored and the index must not move.
    task automatic pause_check(input logic [3:0] s, input int idx);
        logic [8:0] a;
        a = {s, 5'(idx)};
        @(posedge clk); #1;
        play      = 1'b0;
        note_done = 1'b1;
        @(negedge clk);
        chk_eq("pause_nonote", 32'(new_note), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            note_done = 1'b0;
            @(negedge clk);
            chk_eq("pause_nonote", 32'(new_note), 32'd0);
            chk_eq("pause_addr", 32'(rom_addr), 32'(a));
        end
        @(posedge clk); #1;
        play = 1'b1;
        @(negedge clk);
        chk_eq("resume_nonote", 32'(new_note), 32'd0);
        chk_eq("resume_addr", 32'(rom_addr), 32'(a));
    endtask

    // Restarts song s and consumes up to n_stop notes. When the whole song
    // has been consumed, also checks completion. Returns at the negedge of
    // the last checked event.
    task automatic run_song(input logic [3:0] s, input int n_stop, input bit do_pause);
        logic [11:0] q[$];
        logic [8:0]  a;
        for (int i = 0; i < 32; i++) begin
            a = {s, 5'(i)};
            if (rom[a][5:0] == 6'd0) break;
            q.push_back(rom[a]);
        end
        @(posedge clk); #1;
        song         = s;
        reset_player = 1'b1;
        play         = 1'b0;
        note_done    = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        reset_player = 1'b0;
        play         = 1'b1;
        @(negedge clk);
        chk_eq("start_addr", 32'(rom_addr), 32'({s, 5'd0}));
        wait_note("first", 3, q[0]);
        for (int i = 1; i < q.size() && i < n_stop; i++) begin
            if (do_pause && i == 2) pause_check(s, i - 1);
            note_pulse();
            wait_note("note", 3, q[i]);
        end
        if (n_stop < q.size()) return;
        note_pulse();
        wait_done("done", (q.size() == 32) ? 1 : 3);
        chk_eq("done_note_kept", 32'(note), 32'(q[q.size() - 1][11:6]));
        chk_eq("done_dur_kept", 32'(duration), 32'(q[q.size() - 1][5:0]));
`ifdef SONG_READER_LOOP_EN
        wait_note("loop", 3, q[0]);
`else
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            note_done = (c == 2);
            @(negedge clk);
            chk_eq("after_done_nonote", 32'(new_note), 32'd0);
            chk_eq("after_done_nosdone", 32'(song_done), 32'd0);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] a;
        int         pos;
        logic [3:0] s;

        // ROM image: random notes with non-zero durations everywhere.
        for (int i = 0; i < 512; i++) begin
            rom[i] = {6'($urandom), 6'($urandom_range(1, 63))};
        end
        // Songs 6..15 end at a random position.
        for (int k = 6; k < 16; k++) begin
            pos = int'($urandom_range(1, 31));
            a = {4'(k), 5'(pos)};
            rom[a] = {6'($urandom), 6'd0};
        end
        // Song 1: two notes, the second a rest, then the end marker.
        rom[32] = {6'd10, 6'd4};
        rom[33] = {6'd0, 6'd2};
        rom[34] = {6'd0, 6'd0};

        // Asynchronous reset, observed before any clock edge.
        reset        = 1'b1;
        play         = 1'b0;
        reset_player = 1'b0;
        song         = 4'd3;
        note_done    = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk_eq("rst_note", 32'(note), 32'd0);
        chk_eq("rst_dur", 32'(duration), 32'd0);
        chk_eq("rst_new_note", 32'(new_note), 32'd0);
        chk_eq("rst_song_done", 32'(song_done), 32'd0);
        chk_eq("rst_addr", 32'(rom_addr), 32'h060);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_eq("rel_quiet_nn", 32'(new_note), 32'd0);
            chk_eq("rel_quiet_sd", 32'(song_done), 32'd0);
        end

        // Two-note song ending on the end marker.
        run_song(4'd1, 99, 1'b0);
        // Full 32-note song, with a pause in HOLD.
        run_song(4'd2, 99, 1'b1);
        // Random songs of random length.
        for (int r = 0; r < 3; r++) begin
            s = 4'($urandom_range(6, 15));
            run_song(s, 99, 1'($urandom_range(0, 1)));
        end

        // reset_player and note_done together at index 5.
        run_song(4'd4, 6, 1'b0);
        @(posedge clk); #1;
        reset_player = 1'b1;
        note_done    = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        reset_player = 1'b0;
        note_done    = 1'b0;
        @(negedge clk);
        chk_eq("rp_addr_lo", 32'(rom_addr[4:0]), 32'd0);
        chk_eq("rp_addr", 32'(rom_addr), 32'h080);
        chk_eq("rp_nonote", 32'(new_note), 32'd0);
        chk_eq("rp_note_kept", 32'(note), 32'(rom[9'h085][11:6]));
        wait_note("rp_restart", 3, rom[128]);

        // Song change 2 -> 5 in HOLD at index 7.
        run_song(4'd2, 8, 1'b0);
        @(posedge clk); #1;
        song = 4'd5;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk_eq("sw_addr", 32'(rom_addr), 32'h0A0);
        chk_eq("sw_nonote", 32'(new_note), 32'd0);
        wait_note("sw_first", 3, rom[160]);

        // Asynchronous reset in the middle of HOLD, song 3.
        run_song(4'd3, 2, 1'b0);
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        chk_eq("mid_rst_note", 32'(note), 32'd0);
        chk_eq("mid_rst_dur", 32'(duration), 32'd0);
        chk_eq("mid_rst_nn", 32'(new_note), 32'd0);
        chk_eq("mid_rst_sd", 32'(song_done), 32'd0);
        chk_eq("mid_rst_addr", 32'(rom_addr), 32'h060);
        @(negedge clk);
        play  = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_eq("mid_rel_nn", 32'(new_note), 32'd0);
        chk_eq("mid_rel_sd", 32'(song_done), 32'd0);
        @(posedge clk); #1;
        play = 1'b1;
        @(negedge clk);
        wait_note("mid_rel_first", 3, rom[96]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
